rvfi_monitor: RTL and testbench

- Synthesizable RISC-V Formal Interface (RVFI) commit-stream checker for single-issue RV32I cores, such as the RVTU pipeline.
- Sits beside the core in simulation harnesses. It consumes one retired-instruction packet per cycle and checks ordering, PC continuity, register-file consistency and memory-mask legality.
- The first detected violation is latched into a sticky 16-bit error code until reset.

---
 rtl/rvfi_monitor.sv | 124 ++++++++++++
 tb/tb_rvfi_monitor.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_monitor.sv
// rtl/rvfi_monitor.sv - RVFI commit-stream checker with sticky first-error code
module rvfi_monitor (
  input  logic        clock,
  input  logic        reset,
  input  logic        rvfi_valid,
  input  logic [63:0] rvfi_order,
  input  logic [31:0] rvfi_insn,
  input  logic        rvfi_trap,
  input  logic        rvfi_halt,
  input  logic        rvfi_intr,
  input  logic [1:0]  rvfi_mode,
  input  logic [4:0]  rvfi_rs1_addr,
  input  logic [4:0]  rvfi_rs2_addr,
  input  logic [31:0] rvfi_rs1_rdata,
  input  logic [31:0] rvfi_rs2_rdata,
  input  logic [4:0]  rvfi_rd_addr,
  input  logic [31:0] rvfi_rd_wdata,
  input  logic [31:0] rvfi_pc_rdata,
  input  logic [31:0] rvfi_pc_wdata,
  input  logic [31:0] rvfi_mem_addr,
  input  logic [3:0]  rvfi_mem_rmask,
  input  logic [3:0]  rvfi_mem_wmask,
  input  logic [31:0] rvfi_mem_rdata,
  input  logic [31:0] rvfi_mem_wdata,
  input  logic        rvfi_mem_extamo,
  output logic [15:0] errcode
);

  logic [63:0] order_q, order_d;
  logic [31:0] pc_q, pc_d;
  logic        pc_valid_q, pc_valid_d;
  logic [31:0] shadow_q [32];
  logic [31:0] shadow_d [32];
  logic [31:0] shadow_valid_q, shadow_valid_d;
  logic [15:0] errcode_q, errcode_d;
  logic [15:0] code;
  logic        any_mask;

  // Fields carried on the interface but deliberately not checked.
  logic unused_inputs;
  assign unused_inputs = ^{rvfi_insn, rvfi_trap, rvfi_halt, rvfi_mode,
                           rvfi_mem_rdata, rvfi_mem_wdata, rvfi_mem_addr[31:2]};

  function automatic logic mask_legal(input logic [3:0] m);
    case (m)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  assign any_mask = (rvfi_mem_rmask != 4'b0) || (rvfi_mem_wmask != 4'b0);

  // Evaluate all checks against pre-update state; lowest failing code wins.
  always_comb begin
    code = 16'd0;
    if (rvfi_order != order_q)
      code = 16'd101;
    else if (pc_valid_q && !rvfi_intr && (rvfi_pc_rdata != pc_q))
      code = 16'd102;
    else if ((rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != 32'd0))
      code = 16'd103;
    else if ((rvfi_rs1_addr != 5'd0) && shadow_valid_q[rvfi_rs1_addr] &&
             (rvfi_rs1_rdata != shadow_q[rvfi_rs1_addr]))
      code = 16'd104;
    else if ((rvfi_rs2_addr != 5'd0) && shadow_valid_q[rvfi_rs2_addr] &&
             (rvfi_rs2_rdata != shadow_q[rvfi_rs2_addr]))
      code = 16'd105;
    else if ((rvfi_rs1_addr == 5'd0) && (rvfi_rs1_rdata != 32'd0))
      code = 16'd106;
    else if ((rvfi_rs2_addr == 5'd0) && (rvfi_rs2_rdata != 32'd0))
      code = 16'd107;
    else if ((rvfi_mem_rmask != 4'b0) && (rvfi_mem_wmask != 4'b0) && !rvfi_mem_extamo)
      code = 16'd108;
    else if (((rvfi_mem_rmask != 4'b0) && !mask_legal(rvfi_mem_rmask)) ||
             ((rvfi_mem_wmask != 4'b0) && !mask_legal(rvfi_mem_wmask)) ||
             (any_mask && (rvfi_mem_addr[1:0] != 2'b00)))
      code = 16'd109;
    else if ((rvfi_pc_rdata[1:0] != 2'b00) && (rvfi_pc_wdata[1:0] != 2'b00))
      code = 16'd110;
  end

  // Next-state: advance order, PC and shadow registers on every valid packet.
  always_comb begin
    order_d        = order_q;
    pc_d           = pc_q;
    pc_valid_d     = pc_valid_q;
    shadow_d       = shadow_q;
    shadow_valid_d = shadow_valid_q;
    errcode_d      = errcode_q;
    if (rvfi_valid) begin
      order_d    = order_q + 64'd1;
      pc_d       = rvfi_pc_wdata;
      pc_valid_d = 1'b1;
      if (rvfi_rd_addr != 5'd0) begin
        shadow_d[rvfi_rd_addr]       = rvfi_rd_wdata;
        shadow_valid_d[rvfi_rd_addr] = 1'b1;
      end
      if (errcode_q == 16'd0)
        errcode_d = code;
    end
  end

  // State registers; shadow data need no reset because their valid bits do.
  always_ff @(posedge clock) begin
    if (reset) begin
      order_q        <= 64'd0;
      pc_q           <= 32'd0;
      pc_valid_q     <= 1'b0;
      shadow_valid_q <= 32'd0;
      errcode_q      <= 16'd0;
    end else begin
      order_q        <= order_d;
      pc_q           <= pc_d;
      pc_valid_q     <= pc_valid_d;
      shadow_q       <= shadow_d;
      shadow_valid_q <= shadow_valid_d;
      errcode_q      <= errcode_d;
    end
  end

  assign errcode = errcode_q;

endmodule

// File: tb/tb_rvfi_monitor.sv
// tb/tb_rvfi_monitor.sv - table-driven and randomized bench for rvfi_monitor
module tb_rvfi_monitor;

  logic        clock = 1'b0;
  logic        reset;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic        rvfi_trap, rvfi_halt, rvfi_intr;
  logic [1:0]  rvfi_mode;
  logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
  logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
  logic [31:0] rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr;
  logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
  logic [31:0] rvfi_mem_rdata, rvfi_mem_wdata;
  logic        rvfi_mem_extamo;
  logic [15:0] errcode;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  rvfi_monitor dut (
    .clock(clock), .reset(reset), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt),
    .rvfi_intr(rvfi_intr), .rvfi_mode(rvfi_mode),
    .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
    .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
    .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
    .rvfi_mem_wdata(rvfi_mem_wdata), .rvfi_mem_extamo(rvfi_mem_extamo),
    .errcode(errcode)
  );

  typedef struct {
    bit          rst;
    bit          v;
    logic [63:0] ord;
    logic [31:0] pcr, pcw;
    bit          intr;
    logic [4:0]  rs1;
    logic [31:0] r1d;
    logic [4:0]  rs2;
    logic [31:0] r2d;
    logic [4:0]  rd;
    logic [31:0] rdw;
    logic [31:0] addr;
    logic [3:0]  rm, wm;
    bit          amo;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Reference model state: the architectural view a checker must keep.
  logic [63:0] m_ord;
  logic [31:0] m_pc;
  bit          m_pc_v;
  logic [31:0] m_regs [32];
  bit          m_regv [32];
  logic [15:0] m_err;

  function automatic vec_t base(bit rst, logic [63:0] ord, logic [31:0] pcr,
                                logic [31:0] pcw, logic [15:0] exp);
    vec_t t;
    t.rst = rst; t.v = 1'b1; t.ord = ord; t.pcr = pcr; t.pcw = pcw; t.intr = 1'b0;
    t.rs1 = 5'd0; t.r1d = 32'd0; t.rs2 = 5'd0; t.r2d = 32'd0;
    t.rd = 5'd0; t.rdw = 32'd0; t.addr = 32'h80000000;
    t.rm = 4'd0; t.wm = 4'd0; t.amo = 1'b0; t.exp = exp;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    rvfi_valid = t.v; rvfi_order = t.ord; rvfi_pc_rdata = t.pcr; rvfi_pc_wdata = t.pcw;
    rvfi_intr = t.intr; rvfi_rs1_addr = t.rs1; rvfi_rs1_rdata = t.r1d;
    rvfi_rs2_addr = t.rs2; rvfi_rs2_rdata = t.r2d; rvfi_rd_addr = t.rd;
    rvfi_rd_wdata = t.rdw; rvfi_mem_addr = t.addr; rvfi_mem_rmask = t.rm;
    rvfi_mem_wmask = t.wm; rvfi_mem_extamo = t.amo;
    rvfi_insn = $urandom; rvfi_trap = 1'($urandom); rvfi_halt = 1'($urandom);
    rvfi_mode = 2'($urandom); rvfi_mem_rdata = $urandom; rvfi_mem_wdata = $urandom;
  endtask

  task automatic check(input string name, input logic [15:0] exp);
    n_cmp++;
    if (errcode !== exp) begin
      n_bad++;
      $display("FAIL %s: errcode got %0d expected %0d", name, errcode, exp);
    end
  endtask

  // Reset cycle driven with a garbage valid packet, which must be ignored.
  task automatic do_reset();
    vec_t g;
    g = base(1'b0, 64'($urandom), $urandom, $urandom, 16'd0);
    g.rd = 5'($urandom); g.rdw = $urandom; g.rm = 4'($urandom);
    reset = 1'b1;
    drive(g);
    @(posedge clock); #1;
    reset = 1'b0;
    m_ord = 64'd0; m_pc_v = 1'b0; m_err = 16'd0;
    for (int i = 0; i < 32; i++) m_regv[i] = 1'b0;
  endtask

  function automatic bit legal_mask(logic [3:0] m);
    return (m == 4'b0001) || (m == 4'b0010) || (m == 4'b0100) || (m == 4'b1000) ||
           (m == 4'b0011) || (m == 4'b1100) || (m == 4'b1111);
  endfunction

  // Collect every failing rule for the packet on the wires, report the smallest.
  function automatic logic [15:0] model_code();
    int fails[$];
    int best;
    if (rvfi_order != m_ord) fails.push_back(101);
    if (m_pc_v && !rvfi_intr && rvfi_pc_rdata != m_pc) fails.push_back(102);
    if (rvfi_rd_addr == 0 && rvfi_rd_wdata != 0) fails.push_back(103);
    if (rvfi_rs1_addr != 0 && m_regv[rvfi_rs1_addr] && rvfi_rs1_rdata != m_regs[rvfi_rs1_addr])
      fails.push_back(104);
    if (rvfi_rs2_addr != 0 && m_regv[rvfi_rs2_addr] && rvfi_rs2_rdata != m_regs[rvfi_rs2_addr])
      fails.push_back(105);
    if (rvfi_rs1_addr == 0 && rvfi_rs1_rdata != 0) fails.push_back(106);
    if (rvfi_rs2_addr == 0 && rvfi_rs2_rdata != 0) fails.push_back(107);
    if (rvfi_mem_rmask != 0 && rvfi_mem_wmask != 0 && !rvfi_mem_extamo) fails.push_back(108);
    if ((rvfi_mem_rmask != 0 && !legal_mask(rvfi_mem_rmask)) ||
        (rvfi_mem_wmask != 0 && !legal_mask(rvfi_mem_wmask)) ||
        ((rvfi_mem_rmask != 0 || rvfi_mem_wmask != 0) && rvfi_mem_addr % 4 != 0))
      fails.push_back(109);
    if (rvfi_pc_rdata % 4 != 0 && rvfi_pc_wdata % 4 != 0) fails.push_back(110);
    best = 0;
    foreach (fails[k]) if (best == 0 || fails[k] < best) best = fails[k];
    return 16'(best);
  endfunction

  task automatic model_step();
    if (rvfi_valid) begin
      if (m_err == 0) m_err = model_code();
      m_ord  = m_ord + 1;
      m_pc   = rvfi_pc_wdata;
      m_pc_v = 1'b1;
      if (rvfi_rd_addr != 0) begin
        m_regs[rvfi_rd_addr] = rvfi_rd_wdata;
        m_regv[rvfi_rd_addr] = 1'b1;
      end
    end
  endtask

  initial begin
    vec_t t;
    logic [3:0] lm [8];
    lm[0] = 4'b0000; lm[1] = 4'b0001; lm[2] = 4'b0010; lm[3] = 4'b0100;
    lm[4] = 4'b1000; lm[5] = 4'b0011; lm[6] = 4'b1100; lm[7] = 4'b1111;
    for (int i = 0; i < 32; i++) begin m_regs[i] = 32'd0; m_regv[i] = 1'b0; end

    // Sequential stream
    tbl.push_back(base(1, 0, 32'h40000000, 32'h40000004, 0));
    tbl.push_back(base(0, 1, 32'h40000004, 32'h40000008, 0));
    tbl.push_back(base(0, 2, 32'h40000008, 32'h4000000c, 0));
    // Order gap, then later PC error keeps 101
    tbl.push_back(base(1, 0, 32'h0, 32'h4, 0));
    tbl.push_back(base(0, 2, 32'h4, 32'h8, 101));
    tbl.push_back(base(0, 3, 32'h100, 32'h104, 101));
    // Shadow mismatch
    t = base(1, 0, 32'h0, 32'h4, 0); t.rd = 5; t.rdw = 32'h1234; tbl.push_back(t);
    t = base(0, 1, 32'h4, 32'h8, 104); t.rs1 = 5; t.r1d = 32'h1235; tbl.push_back(t);
    // Shadow match, then rd=rs1 in one packet checks the old value
    t = base(1, 0, 32'h0, 32'h4, 0); t.rd = 5; t.rdw = 32'h1234; tbl.push_back(t);
    t = base(0, 1, 32'h4, 32'h8, 0); t.rs1 = 5; t.r1d = 32'h1234; tbl.push_back(t);
    t = base(0, 2, 32'h8, 32'hc, 0); t.rs1 = 5; t.r1d = 32'h1234; t.rd = 5; t.rdw = 32'h9999;
    tbl.push_back(t);
    t = base(0, 3, 32'hc, 32'h10, 0); t.rs2 = 5; t.r2d = 32'h9999; tbl.push_back(t);
    t = base(0, 4, 32'h10, 32'h14, 105); t.rs2 = 5; t.r2d = 32'h1234; tbl.push_back(t);
    // After reset the shadow entries are invalid again
    t = base(1, 0, 32'h0, 32'h4, 0); t.rs1 = 5; t.r1d = 32'hdead; tbl.push_back(t);
    // PC jump with and without intr
    tbl.push_back(base(1, 0, 32'h40000004, 32'h40000008, 0));
    tbl.push_back(base(0, 1, 32'h40000010, 32'h40000014, 102));
    tbl.push_back(base(1, 0, 32'h40000004, 32'h40000008, 0));
    t = base(0, 1, 32'h40000010, 32'h40000014, 0); t.intr = 1; tbl.push_back(t);
    // First packet after reset skips PC continuity
    tbl.push_back(base(1, 0, 32'h50000000, 32'h50000004, 0));
    // Memory masks
    t = base(1, 0, 32'h0, 32'h4, 109); t.rm = 4'b0110; tbl.push_back(t);
    t = base(1, 0, 32'h0, 32'h4, 0); t.wm = 4'b1100; tbl.push_back(t);
    t = base(0, 1, 32'h4, 32'h8, 108); t.rm = 4'b1111; t.wm = 4'b0001; tbl.push_back(t);
    t = base(1, 0, 32'h0, 32'h4, 0); t.rm = 4'b1111; t.wm = 4'b0001; t.amo = 1; tbl.push_back(t);
    t = base(1, 0, 32'h0, 32'h4, 109); t.addr = 32'h80000002; t.rm = 4'b0001; tbl.push_back(t);
    // Same-packet priority, then reset and a clean packet
    t = base(1, 1, 32'h0, 32'h4, 101); t.rdw = 5; tbl.push_back(t);
    tbl.push_back(base(1, 0, 32'h0, 32'h4, 0));
    // Zero-register rules and PC alignment
    t = base(0, 1, 32'h4, 32'h8, 103); t.rdw = 5; t.r1d = 1; tbl.push_back(t);
    t = base(1, 0, 32'h0, 32'h4, 106); t.r1d = 1; t.r2d = 7; tbl.push_back(t);
    t = base(1, 0, 32'h0, 32'h4, 107); t.r2d = 7; tbl.push_back(t);
    t = base(1, 0, 32'h2, 32'h6, 110); tbl.push_back(t);
    // Idle cycle with garbage does not count
    tbl.push_back(base(1, 0, 32'h0, 32'h4, 0));
    t = base(0, 5, 32'h99, 32'h77, 0); t.v = 0; t.rdw = 3; tbl.push_back(t);
    tbl.push_back(base(0, 1, 32'h4, 32'h8, 0));

    reset = 1'b0;
    do_reset();
    check("reset_state", 16'd0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      drive(tbl[i]);
      @(posedge clock); #1;
      check($sformatf("vec%0d", i), tbl[i].exp);
    end

    // Randomized stream checked against the model
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 59) == 0 || (m_err != 0 && $urandom_range(0, 7) == 0)) begin
        do_reset();
        check("rand_reset", 16'd0);
      end
      t = base(0, m_ord, 32'h0, 32'h0, 0);
      t.v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 79) == 0) t.ord = m_ord + 64'($urandom_range(1, 3));
      t.intr = ($urandom_range(0, 19) == 0);
      t.pcr = (m_pc_v && !t.intr) ? m_pc : {$urandom_range(0, 32'h3fffffff), 2'b00};
      if ($urandom_range(0, 79) == 0) t.pcr = t.pcr ^ 32'h4;
      if ($urandom_range(0, 79) == 0) t.pcr = t.pcr | 32'($urandom_range(1, 3));
      t.pcw = t.pcr + 32'd4;
      if ($urandom_range(0, 29) == 0) t.pcw = $urandom;
      t.rs1 = 5'($urandom_range(0, 7));
      t.rs2 = 5'($urandom_range(0, 7));
      t.r1d = (t.rs1 == 0) ? 32'd0 : (m_regv[t.rs1] ? m_regs[t.rs1] : $urandom);
      t.r2d = (t.rs2 == 0) ? 32'd0 : (m_regv[t.rs2] ? m_regs[t.rs2] : $urandom);
      if ($urandom_range(0, 79) == 0) t.r1d = t.r1d ^ 32'h10;
      if ($urandom_range(0, 79) == 0) t.r2d = t.r2d ^ 32'h1;
      t.rd = 5'($urandom_range(0, 7));
      t.rdw = (t.rd == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 79) == 0) t.rdw = 32'd9;
      if ($urandom_range(0, 1) == 0) t.rm = lm[$urandom_range(0, 7)];
      else t.wm = lm[$urandom_range(0, 7)];
      if ($urandom_range(0, 49) == 0) begin t.rm = 4'($urandom); t.wm = 4'($urandom); end
      t.amo = ($urandom_range(0, 3) == 0);
      t.addr = {$urandom_range(0, 32'h3fffffff), 2'b00};
      if ($urandom_range(0, 59) == 0) t.addr = t.addr | 32'($urandom_range(1, 3));
      drive(t);
      model_step();
      @(posedge clock); #1;
      check("random", m_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
